warp_barrier_unit: RTL and testbench

- Receiving end of the per-warp barrier request (valid, id, is_global, size_m1) issued by the execute stage's GPU unit.
- Tracks, per barrier id, which warps are parked and how many have arrived.
- Releases the parked warps to the warp scheduler once a local barrier completes.
- For global barriers, issues one request to the cluster-level barrier once every active warp has arrived, and releases the parked warps on the matching cluster response.

---
 rtl/warp_barrier_unit.sv | 155 +++++++++++++++
 tb/tb_warp_barrier_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/warp_barrier_unit.sv
// Per-core warp barrier tracker: parks arriving warps per barrier id, releases them on
// local completion, and forwards global barriers to the cluster once all active warps arrive.
module warp_barrier_unit #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_BARRIERS = 4,
    parameter int NUM_CORES    = 4,
    localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int NB_BITS = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
    localparam int NC_BITS = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    localparam int SIZE_W  = (NW_BITS > NC_BITS) ? NW_BITS : NC_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bar_req_valid,
    output logic                 bar_req_ready,
    input  logic [NW_BITS-1:0]   bar_req_wid,
    input  logic [NB_BITS-1:0]   bar_req_id,
    input  logic                 bar_req_is_global,
    input  logic [SIZE_W-1:0]    bar_req_size_m1,
    input  logic [NUM_WARPS-1:0] active_warps,
    output logic [NUM_WARPS-1:0] stalled_warps,
    output logic                 release_valid,
    output logic [NUM_WARPS-1:0] release_wmask,
    output logic                 gbar_req_valid,
    input  logic                 gbar_req_ready,
    output logic [NB_BITS-1:0]   gbar_req_id,
    output logic [SIZE_W-1:0]    gbar_req_size_m1,
    input  logic                 gbar_rsp_valid,
    input  logic [NB_BITS-1:0]   gbar_rsp_id
);
    localparam int CNT_W = NW_BITS + 1;
    localparam int CMP_W = (CNT_W > SIZE_W) ? CNT_W : SIZE_W;

    logic [NUM_WARPS-1:0] wait_mask [NUM_BARRIERS];
    logic [CNT_W-1:0]     count     [NUM_BARRIERS];
    logic [SIZE_W-1:0]    size_m1   [NUM_BARRIERS];
    logic [NUM_BARRIERS-1:0] is_global;
    logic [NUM_BARRIERS-1:0] gsent;

    logic [NUM_WARPS-1:0] nxt_mask  [NUM_BARRIERS];
    logic [CNT_W-1:0]     nxt_count [NUM_BARRIERS];
    logic [SIZE_W-1:0]    nxt_size  [NUM_BARRIERS];
    logic [NUM_BARRIERS-1:0] nxt_global;
    logic [NUM_BARRIERS-1:0] nxt_gsent;
    logic [NUM_WARPS-1:0] rel_mask;
    logic [NUM_WARPS-1:0] stall_nxt;
    logic [NUM_WARPS-1:0] new_bit;
    logic [NUM_WARPS-1:0] merged;
    logic [SIZE_W-1:0]    eff_size;
    logic                 accept;
    logic                 load_gbar;
    logic                 dup_arrival;
    logic                 idle_rsp;

    // Handshakes are valid/ready: a transfer happens on any edge where both are high;
    // a source holds its payload stable while valid is high and ready is low.
    // Arrivals stall while a global send is pending, so only one is ever outstanding.
    assign bar_req_ready = !reset && !gbar_req_valid;
    assign accept        = bar_req_valid && bar_req_ready;
    assign new_bit       = NUM_WARPS'(1) << bar_req_wid;

    always_comb begin
        nxt_mask    = wait_mask;
        nxt_count   = count;
        nxt_size    = size_m1;
        nxt_global  = is_global;
        nxt_gsent   = gsent;
        rel_mask    = '0;
        load_gbar   = 1'b0;
        dup_arrival = 1'b0;
        idle_rsp    = 1'b0;
        merged      = '0;
        eff_size    = '0;
        stall_nxt   = '0;

        // The response clear comes first so a same-cycle arrival opens a new episode.
        if (gbar_rsp_valid) begin
            if (gsent[gbar_rsp_id]) begin
                rel_mask                 = rel_mask | nxt_mask[gbar_rsp_id];
                nxt_mask[gbar_rsp_id]    = '0;
                nxt_count[gbar_rsp_id]   = '0;
                nxt_global[gbar_rsp_id]  = 1'b0;
                nxt_gsent[gbar_rsp_id]   = 1'b0;
            end else begin
                idle_rsp = 1'b1;
            end
        end

        if (accept) begin
            eff_size = (nxt_mask[bar_req_id] == '0) ? bar_req_size_m1 : nxt_size[bar_req_id];
            merged   = nxt_mask[bar_req_id] | new_bit;
            if ((nxt_mask[bar_req_id] & new_bit) != '0) begin
                dup_arrival = 1'b1;
            end else if (!bar_req_is_global) begin
                if (CMP_W'(nxt_count[bar_req_id]) == CMP_W'(eff_size)) begin
                    rel_mask              = rel_mask | merged;
                    nxt_mask[bar_req_id]  = '0;
                    nxt_count[bar_req_id] = '0;
                end else begin
                    nxt_mask[bar_req_id]  = merged;
                    nxt_count[bar_req_id] = nxt_count[bar_req_id] + CNT_W'(1);
                    nxt_size[bar_req_id]  = eff_size;
                end
            end else begin
                nxt_mask[bar_req_id]   = merged;
                nxt_global[bar_req_id] = 1'b1;
                nxt_size[bar_req_id]   = eff_size;
                if (((merged & active_warps) == active_warps) && !nxt_gsent[bar_req_id]) begin
                    load_gbar             = 1'b1;
                    nxt_gsent[bar_req_id] = 1'b1;
                end
            end
        end

        for (int b = 0; b < NUM_BARRIERS; b++) begin
            stall_nxt = stall_nxt | nxt_mask[b];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                wait_mask[b] <= '0;
                count[b]     <= '0;
                size_m1[b]   <= '0;
            end
            is_global        <= '0;
            gsent            <= '0;
            stalled_warps    <= '0;
            release_valid    <= 1'b0;
            release_wmask    <= '0;
            gbar_req_valid   <= 1'b0;
            gbar_req_id      <= '0;
            gbar_req_size_m1 <= '0;
        end else begin
            wait_mask     <= nxt_mask;
            count         <= nxt_count;
            size_m1       <= nxt_size;
            is_global     <= nxt_global;
            gsent         <= nxt_gsent;
            stalled_warps <= stall_nxt;
            release_valid <= (rel_mask != '0);
            release_wmask <= rel_mask;
            if (load_gbar) begin
                gbar_req_valid   <= 1'b1;
                gbar_req_id      <= bar_req_id;
                gbar_req_size_m1 <= eff_size;
            end else if (gbar_req_valid && gbar_req_ready) begin
                gbar_req_valid <= 1'b0;
            end
            assert (!dup_arrival) else $warning("duplicate barrier arrival dropped");
            assert (!idle_rsp) else $warning("cluster barrier response for idle id ignored");
        end
    end
endmodule

// File: tb/tb_warp_barrier_unit.sv
// Directed bench for warp_barrier_unit: local, global, merge, duplicate and reset scenarios.
module tb_warp_barrier_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic       bar_req_valid;
  logic       bar_req_ready;
  logic [1:0] bar_req_wid;
  logic [1:0] bar_req_id;
  logic       bar_req_is_global;
  logic [1:0] bar_req_size_m1;
  logic [3:0] active_warps;
  logic [3:0] stalled_warps;
  logic       release_valid;
  logic [3:0] release_wmask;
  logic       gbar_req_valid;
  logic       gbar_req_ready;
  logic [1:0] gbar_req_id;
  logic [1:0] gbar_req_size_m1;
  logic       gbar_rsp_valid;
  logic [1:0] gbar_rsp_id;

  int n_cmp = 0;
  int n_bad = 0;

  warp_barrier_unit dut (
    .clk(clk), .reset(reset),
    .bar_req_valid(bar_req_valid), .bar_req_ready(bar_req_ready),
    .bar_req_wid(bar_req_wid), .bar_req_id(bar_req_id),
    .bar_req_is_global(bar_req_is_global), .bar_req_size_m1(bar_req_size_m1),
    .active_warps(active_warps), .stalled_warps(stalled_warps),
    .release_valid(release_valid), .release_wmask(release_wmask),
    .gbar_req_valid(gbar_req_valid), .gbar_req_ready(gbar_req_ready),
    .gbar_req_id(gbar_req_id), .gbar_req_size_m1(gbar_req_size_m1),
    .gbar_rsp_valid(gbar_rsp_valid), .gbar_rsp_id(gbar_rsp_id)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: present one arrival, wait (bounded) for ready, complete it on one edge
  task automatic arrive(input logic [1:0] w, input logic [1:0] id, input logic g, input logic [1:0] sz);
    int waited = 0;
    bar_req_valid = 1'b1;
    bar_req_wid = w;
    bar_req_id = id;
    bar_req_is_global = g;
    bar_req_size_m1 = sz;
    while (!bar_req_ready && waited < 20) begin
      step();
      waited++;
    end
    n_cmp++;
    if (!bar_req_ready) begin
      $display("FAIL arrive_timeout: ready got %b want 1", bar_req_ready);
      n_bad++;
    end
    step();
    bar_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++; if (stalled_warps !== 4'b0000) begin $display("FAIL rst_stalled: got %b want 0000", stalled_warps); n_bad++; end
    n_cmp++; if (release_valid !== 1'b0) begin $display("FAIL rst_rel_valid: got %b want 0", release_valid); n_bad++; end
    n_cmp++; if (release_wmask !== 4'b0000) begin $display("FAIL rst_rel_wmask: got %b want 0000", release_wmask); n_bad++; end
    n_cmp++; if (gbar_req_valid !== 1'b0) begin $display("FAIL rst_gbar_valid: got %b want 0", gbar_req_valid); n_bad++; end
    n_cmp++; if (gbar_req_id !== 2'd0 || gbar_req_size_m1 !== 2'd0) begin $display("FAIL rst_gbar_fields: got id %0d size %0d want 0 0", gbar_req_id, gbar_req_size_m1); n_bad++; end
    n_cmp++; if (bar_req_ready !== 1'b0) begin $display("FAIL rst_ready_low: got %b want 0", bar_req_ready); n_bad++; end
    reset = 1'b0;
    #1;
    n_cmp++; if (bar_req_ready !== 1'b1) begin $display("FAIL rst_ready_high: got %b want 1", bar_req_ready); n_bad++; end
  endtask

  task automatic test_local();
    arrive(2'd0, 2'd1, 1'b0, 2'd2);
    n_cmp++; if (stalled_warps !== 4'b0001) begin $display("FAIL loc_stall1: got %b want 0001", stalled_warps); n_bad++; end
    arrive(2'd2, 2'd1, 1'b0, 2'd2);
    n_cmp++; if (stalled_warps !== 4'b0101) begin $display("FAIL loc_stall2: got %b want 0101", stalled_warps); n_bad++; end
    n_cmp++; if (release_valid !== 1'b0) begin $display("FAIL loc_early_rel: got %b want 0", release_valid); n_bad++; end
    arrive(2'd3, 2'd1, 1'b0, 2'd2);
    n_cmp++; if (release_valid !== 1'b1) begin $display("FAIL loc_rel_valid: got %b want 1", release_valid); n_bad++; end
    n_cmp++; if (release_wmask !== 4'b1101) begin $display("FAIL loc_rel_wmask: got %b want 1101", release_wmask); n_bad++; end
    n_cmp++; if (stalled_warps !== 4'b0000) begin $display("FAIL loc_stall_clr: got %b want 0000", stalled_warps); n_bad++; end
    step();
    n_cmp++; if (release_valid !== 1'b0) begin $display("FAIL loc_pulse_len: got %b want 0", release_valid); n_bad++; end
  endtask

  task automatic test_size_zero();
    arrive(2'd2, 2'd0, 1'b0, 2'd0);
    n_cmp++; if (release_valid !== 1'b1) begin $display("FAIL sz0_rel_valid: got %b want 1", release_valid); n_bad++; end
    n_cmp++; if (release_wmask !== 4'b0100) begin $display("FAIL sz0_rel_wmask: got %b want 0100", release_wmask); n_bad++; end
    n_cmp++; if (stalled_warps !== 4'b0000) begin $display("FAIL sz0_stalled: got %b want 0000", stalled_warps); n_bad++; end
    step();
  endtask

  task automatic test_global();
    active_warps = 4'b0011;
    gbar_req_ready = 1'b0;
    arrive(2'd0, 2'd3, 1'b1, 2'd3);
    n_cmp++; if (gbar_req_valid !== 1'b0) begin $display("FAIL glb_early_req: got %b want 0", gbar_req_valid); n_bad++; end
    arrive(2'd1, 2'd3, 1'b1, 2'd3);
    n_cmp++; if (gbar_req_valid !== 1'b1 || gbar_req_id !== 2'd3 || gbar_req_size_m1 !== 2'd3) begin
      $display("FAIL glb_req: got v%b id %0d size %0d want v1 id 3 size 3", gbar_req_valid, gbar_req_id, gbar_req_size_m1); n_bad++; end
    n_cmp++; if (stalled_warps !== 4'b0011) begin $display("FAIL glb_stalled: got %b want 0011", stalled_warps); n_bad++; end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (gbar_req_valid !== 1'b1 || bar_req_ready !== 1'b0) begin
        $display("FAIL glb_hold%0d: got valid %b ready %b want 1 0", i, gbar_req_valid, bar_req_ready); n_bad++; end
    end
    gbar_req_ready = 1'b1;
    step();
    gbar_req_ready = 1'b0;
    n_cmp++; if (gbar_req_valid !== 1'b0 || bar_req_ready !== 1'b1) begin
      $display("FAIL glb_handshake: got valid %b ready %b want 0 1", gbar_req_valid, bar_req_ready); n_bad++; end
    n_cmp++; if (release_valid !== 1'b0) begin $display("FAIL glb_no_rel: got %b want 0", release_valid); n_bad++; end
    gbar_rsp_valid = 1'b1;
    gbar_rsp_id = 2'd3;
    step();
    gbar_rsp_valid = 1'b0;
    n_cmp++; if (release_valid !== 1'b1 || release_wmask !== 4'b0011) begin
      $display("FAIL glb_release: got v%b mask %b want v1 mask 0011", release_valid, release_wmask); n_bad++; end
    n_cmp++; if (stalled_warps !== 4'b0000) begin $display("FAIL glb_stall_clr: got %b want 0000", stalled_warps); n_bad++; end
    step();
  endtask

  task automatic test_merge();
    active_warps = 4'b1000;
    gbar_req_ready = 1'b1;
    arrive(2'd3, 2'd2, 1'b1, 2'd3);
    n_cmp++; if (gbar_req_valid !== 1'b1 || gbar_req_id !== 2'd2) begin
      $display("FAIL mrg_req: got v%b id %0d want v1 id 2", gbar_req_valid, gbar_req_id); n_bad++; end
    step();
    gbar_req_ready = 1'b0;
    arrive(2'd0, 2'd0, 1'b0, 2'd1);
    n_cmp++; if (stalled_warps !== 4'b1001) begin $display("FAIL mrg_stalled: got %b want 1001", stalled_warps); n_bad++; end
    bar_req_valid = 1'b1;
    bar_req_wid = 2'd1;
    bar_req_id = 2'd0;
    bar_req_is_global = 1'b0;
    bar_req_size_m1 = 2'd1;
    gbar_rsp_valid = 1'b1;
    gbar_rsp_id = 2'd2;
    n_cmp++; if (bar_req_ready !== 1'b1) begin $display("FAIL mrg_ready: got %b want 1", bar_req_ready); n_bad++; end
    step();
    bar_req_valid = 1'b0;
    gbar_rsp_valid = 1'b0;
    n_cmp++; if (release_valid !== 1'b1 || release_wmask !== 4'b1011) begin
      $display("FAIL mrg_release: got v%b mask %b want v1 mask 1011", release_valid, release_wmask); n_bad++; end
    n_cmp++; if (stalled_warps !== 4'b0000) begin $display("FAIL mrg_stall_clr: got %b want 0000", stalled_warps); n_bad++; end
    step();
    n_cmp++; if (release_valid !== 1'b0) begin $display("FAIL mrg_single_pulse: got %b want 0", release_valid); n_bad++; end
  endtask

  task automatic test_duplicate();
    arrive(2'd1, 2'd0, 1'b0, 2'd1);
    arrive(2'd1, 2'd0, 1'b0, 2'd1);
    n_cmp++; if (release_valid !== 1'b0) begin $display("FAIL dup_no_rel: got %b want 0", release_valid); n_bad++; end
    n_cmp++; if (stalled_warps !== 4'b0010) begin $display("FAIL dup_stalled: got %b want 0010", stalled_warps); n_bad++; end
    arrive(2'd2, 2'd0, 1'b0, 2'd1);
    n_cmp++; if (release_valid !== 1'b1 || release_wmask !== 4'b0110) begin
      $display("FAIL dup_release: got v%b mask %b want v1 mask 0110", release_valid, release_wmask); n_bad++; end
    step();
  endtask

  task automatic test_reset_mid();
    arrive(2'd0, 2'd1, 1'b0, 2'd2);
    arrive(2'd1, 2'd1, 1'b0, 2'd2);
    n_cmp++; if (stalled_warps !== 4'b0011) begin $display("FAIL rmid_parked: got %b want 0011", stalled_warps); n_bad++; end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (stalled_warps !== 4'b0000 || release_valid !== 1'b0) begin
      $display("FAIL rmid_cleared: got stall %b rel %b want 0000 0", stalled_warps, release_valid); n_bad++; end
    step();
    n_cmp++; if (release_valid !== 1'b0) begin $display("FAIL rmid_no_rel: got %b want 0", release_valid); n_bad++; end
    test_local();
  endtask

  initial begin
    reset = 1'b1;
    bar_req_valid = 1'b0;
    bar_req_wid = '0;
    bar_req_id = '0;
    bar_req_is_global = 1'b0;
    bar_req_size_m1 = '0;
    active_warps = 4'b1111;
    gbar_req_ready = 1'b0;
    gbar_rsp_valid = 1'b0;
    gbar_rsp_id = '0;
    test_reset();
    test_local();
    test_size_zero();
    test_global();
    test_merge();
    test_duplicate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
